// File: rtl/pipelined_control_unit_if.sv
// Fetch-side handshake and ID/EX-side control bundle for the pipelined control unit.
// slave is the decoder's view; master is the driver's view (fetch + hazard logic + ID/EX sink).
interface pipelined_control_unit_if #(
    parameter int INSTR_W = 16,
    parameter int STEP_W  = 2
);
    logic [INSTR_W-1:0] instr_i;
    logic               instr_valid_i;
    logic               ready_o;
    logic               stall_i;
    logic               flush_i;
    logic [19:0]        ctrl_o;
    logic               ctrl_valid_o;
    logic [INSTR_W-1:0] imm_o;
    logic [STEP_W-1:0]  step_o;
    logic               illegal_o;
    logic               busy_o;

    modport slave (
        input  instr_i, instr_valid_i, stall_i, flush_i,
        output ready_o, ctrl_o, ctrl_valid_o, imm_o, step_o, illegal_o, busy_o
    );

    modport master (
        output instr_i, instr_valid_i, stall_i, flush_i,
        input  ready_o, ctrl_o, ctrl_valid_o, imm_o, step_o, illegal_o, busy_o
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered opcode decoder: assembles two-word immediates and sequences call/ret/rti steps.
// Control is valid one cycle after the (last) word is accepted; ready drops on stall/flush and during stack steps.
module pipelined_control_unit #(
    parameter int INSTR_W     = 16,
    parameter int STACK_WORDS = 2,
    parameter int STEP_W      = $clog2(STACK_WORDS + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipelined_control_unit_if.slave  bus
);
    typedef enum logic [1:0] {DECODE, IMM, MULTI} state_t;

    localparam logic [STEP_W-1:0] LAST_CR  = STEP_W'(STACK_WORDS - 1);
    localparam logic [STEP_W-1:0] LAST_RTI = STEP_W'(STACK_WORDS);

    state_t             state_q;
    logic [4:0]         op_q;
    logic [19:0]        ctrl_q;
    logic               vld_q;
    logic               ill_q;
    logic [INSTR_W-1:0] imm_q;
    logic [STEP_W-1:0]  step_q;

    logic [4:0]         op_in;
    logic [STEP_W-1:0]  last_step;

    function automatic logic is_rsvd(input logic [4:0] op);
        return (op[4:2] == 3'b010) || (op == 5'b10111);
    endfunction

    function automatic logic is_two(input logic [4:0] op);
        return (op == 5'b00111) || (op == 5'b01110) || (op == 5'b01111) ||
               (op == 5'b10100) || (op == 5'b10101);
    endfunction

    function automatic logic is_stack(input logic [4:0] op);
        return (op == 5'b11100) || (op == 5'b11101) || (op == 5'b11110);
    endfunction

    function automatic logic [19:0] decode(input logic [4:0] op);
        logic [19:0] c;
        c = '0;
        case (op)
            5'b00000: begin c[11] = 1'b1; c[0] = 1'b1; end                     // add
            5'b00001: c[11] = 1'b1;                                             // setc
            5'b00010: begin c[11] = 1'b1; c[0] = 1'b1; end                     // inc
            5'b00011: c[11] = 1'b1;                                             // clrc
            5'b00100: c[4] = 1'b1;                                              // out
            5'b00101: begin c[19] = 1'b1; c[0] = 1'b1; end                     // mov
            5'b00110: begin c[5] = 1'b1; c[0] = 1'b1; end                      // in
            5'b00111: begin c[15] = 1'b1; c[14] = 1'b1; c[0] = 1'b1; end       // ldm
            5'b01100: begin c[10] = 1'b1; c[1] = 1'b1; end                     // push
            5'b01101: begin c[9] = 1'b1; c[2] = 1'b1; c[0] = 1'b1; end         // pop
            5'b01110: begin c[14] = 1'b1; c[6] = 1'b1; c[2] = 1'b1; c[0] = 1'b1; end // ldd
            5'b01111: begin c[14] = 1'b1; c[13] = 1'b1; c[1] = 1'b1; end       // std
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110:
                      begin c[11] = 1'b1; c[0] = 1'b1; end                     // dec/sub/or/and/not
            5'b10100, 5'b10101:
                      begin c[14] = 1'b1; c[11] = 1'b1; c[0] = 1'b1; end       // shl/shr
            5'b11000: c[16] = 1'b1;
            5'b11001: c[17] = 1'b1;
            5'b11010: c[18] = 1'b1;
            5'b11011: c[12] = 1'b1;
            5'b11100: begin c[8] = 1'b1; c[2] = 1'b1; end                      // ret
            5'b11101: begin c[7] = 1'b1; c[2] = 1'b1; end                      // rti
            5'b11110: begin c[3] = 1'b1; c[1] = 1'b1; end                      // call
            default:  c = '0;                                                   // nop, reserved
        endcase
        return c;
    endfunction

    assign op_in     = bus.instr_i[INSTR_W-1 -: 5];
    // rti pops the flags word on top of the PC words, hence one extra step
    assign last_step = ctrl_q[7] ? LAST_RTI : LAST_CR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DECODE;
            op_q    <= '0;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
            imm_q   <= '0;
            step_q  <= '0;
        end else if (bus.flush_i) begin
            state_q <= DECODE;
            op_q    <= '0;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
            step_q  <= '0;
        end else if (!bus.stall_i) begin
            ill_q <= 1'b0;
            case (state_q)
                DECODE: begin
                    if (bus.instr_valid_i) begin
                        if (is_rsvd(op_in)) begin
                            ctrl_q <= '0;
                            vld_q  <= 1'b1;
                            ill_q  <= 1'b1;
                            imm_q  <= '0;
                        end else if (is_two(op_in)) begin
                            op_q    <= op_in;
                            vld_q   <= 1'b0;
                            state_q <= IMM;
                        end else begin
                            ctrl_q <= decode(op_in);
                            vld_q  <= 1'b1;
                            imm_q  <= '0;
                            step_q <= '0;
                            if (is_stack(op_in)) state_q <= MULTI;
                        end
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                IMM: begin
                    if (bus.instr_valid_i) begin
                        imm_q   <= bus.instr_i;
                        ctrl_q  <= decode(op_q);
                        vld_q   <= 1'b1;
                        state_q <= DECODE;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                MULTI: begin
                    if (step_q == last_step) begin
                        state_q <= DECODE;
                        step_q  <= '0;
                        vld_q   <= 1'b0;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                default: state_q <= DECODE;
            endcase
        end
    end

    assign bus.ready_o      = !bus.stall_i && !bus.flush_i &&
                              (state_q == DECODE || state_q == IMM);
    assign bus.busy_o       = (state_q != DECODE);
    assign bus.ctrl_o       = ctrl_q;
    assign bus.ctrl_valid_o = vld_q;
    assign bus.imm_o        = imm_q;
    assign bus.step_o       = step_q;
    assign bus.illegal_o    = ill_q;
endmodule
